// File: rtl/legv8_exec_ctrl_pkg.sv
// Shared LEGv8 execute-stage definitions: opcodes, ALUOp / ALU control
// encodings and the packed bundle of datapath control signals.
package legv8_exec_ctrl_pkg;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [7:0]  OP_CBZ_PREFIX = 8'hB4;   // opcode[10:3]
    localparam logic [5:0]  OP_B_PREFIX   = 6'b000101; // opcode[10:5]

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    typedef struct packed {
        logic reg2loc;
        logic alu_src;
        logic mem2reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic uncon_branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/legv8_alu.sv
// Combinational LEGv8 ALU; also used by the PC adders, so it has no clock.
module legv8_alu
    import legv8_exec_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND:  result = a & b;
            ALU_ORR:  result = a | b;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_PASS: result = b;
            ALU_NOR:  result = ~(a | b);
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/legv8_exec_ctrl.sv
// LEGv8 execute slice: opcode decode, ALU control, ALU, and one output
// register stage between register read and memory/write-back.
module legv8_exec_ctrl
    import legv8_exec_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [10:0]     opcode,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    output logic            reg2loc,
    output logic            alu_src,
    output logic            mem2reg,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            uncon_branch,
    output logic [1:0]      alu_op,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    function automatic void decode(input logic [10:0] op,
                                   output ctrl_t c,
                                   output logic [1:0] aop,
                                   output logic ill);
        c   = CTRL_NONE;
        aop = ALUOP_MEM;
        ill = 1'b0;
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
            c.reg_write = 1'b1;
            aop         = ALUOP_RTYPE;
        end else if (op == OP_LDUR) begin
            c.alu_src   = 1'b1;
            c.mem2reg   = 1'b1;
            c.reg_write = 1'b1;
            c.mem_read  = 1'b1;
        end else if (op == OP_STUR) begin
            c.reg2loc   = 1'b1;
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
        end else if (op[10:3] == OP_CBZ_PREFIX) begin
            c.reg2loc = 1'b1;
            c.branch  = 1'b1;
            aop       = ALUOP_BRANCH;
        end else if (op[10:5] == OP_B_PREFIX) begin
            c.uncon_branch = 1'b1;
        end else begin
            ill = 1'b1;
        end
    endfunction

    function automatic logic [3:0] alu_control(input logic [1:0] aop,
                                               input logic [10:0] op);
        logic [3:0] code;
        code = ALU_ADD;
        case (aop)
            ALUOP_MEM:    code = ALU_ADD;
            ALUOP_BRANCH: code = ALU_PASS;
            ALUOP_RTYPE: begin
                case (op)
                    OP_SUB:  code = ALU_SUB;
                    OP_AND:  code = ALU_AND;
                    OP_ORR:  code = ALU_ORR;
                    default: code = ALU_ADD;
                endcase
            end
            default:      code = ALU_ADD;
        endcase
        return code;
    endfunction

    ctrl_t            dec_ctrl;
    logic [1:0]       dec_alu_op;
    logic             dec_illegal;
    logic [3:0]       dec_alu_ctrl;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  alu_result;
    logic             alu_zero;

    always_comb begin
        decode(opcode, dec_ctrl, dec_alu_op, dec_illegal);
        dec_alu_ctrl = alu_control(dec_alu_op, opcode);
    end

    assign alu_b = dec_ctrl.alu_src ? imm : rs2_data;

    legv8_alu #(.XLEN(XLEN)) u_alu (
        .a      (rs1_data),
        .b      (alu_b),
        .ctrl   (dec_alu_ctrl),
        .result (alu_result),
        .zero   (alu_zero)
    );

    logic            valid_q;
    ctrl_t           ctrl_q,     ctrl_d;
    logic [1:0]      alu_op_q,   alu_op_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    logic            illegal_q,  illegal_d;
    logic [XLEN-1:0] result_q,   result_d;
    logic            zero_q,     zero_d;

    // A bubble clears every control output but leaves result/zero untouched.
    always_comb begin
        ctrl_d     = CTRL_NONE;
        alu_op_d   = ALUOP_MEM;
        alu_ctrl_d = 4'b0000;
        illegal_d  = 1'b0;
        result_d   = result_q;
        zero_d     = zero_q;
        if (in_valid) begin
            ctrl_d     = dec_ctrl;
            alu_op_d   = dec_alu_op;
            alu_ctrl_d = dec_alu_ctrl;
            illegal_d  = dec_illegal;
            result_d   = alu_result;
            zero_d     = alu_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= CTRL_NONE;
            alu_op_q   <= 2'b00;
            alu_ctrl_q <= 4'b0000;
            illegal_q  <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else begin
            valid_q    <= in_valid;
            ctrl_q     <= ctrl_d;
            alu_op_q   <= alu_op_d;
            alu_ctrl_q <= alu_ctrl_d;
            illegal_q  <= illegal_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid    = valid_q;
    assign reg2loc      = ctrl_q.reg2loc;
    assign alu_src      = ctrl_q.alu_src;
    assign mem2reg      = ctrl_q.mem2reg;
    assign reg_write    = ctrl_q.reg_write;
    assign mem_read     = ctrl_q.mem_read;
    assign mem_write    = ctrl_q.mem_write;
    assign branch       = ctrl_q.branch;
    assign uncon_branch = ctrl_q.uncon_branch;
    assign alu_op       = alu_op_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_legv8_exec_ctrl.sv
// Directed, table-driven bench for legv8_exec_ctrl with hand-computed results.
module tb_legv8_exec_ctrl;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [10:0]     opcode;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic            out_valid, reg2loc, alu_src, mem2reg, reg_write;
    logic            mem_read, mem_write, branch, uncon_branch;
    logic [1:0]      alu_op;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] result;
    logic            zero, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    legv8_exec_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .out_valid(out_valid), .reg2loc(reg2loc), .alu_src(alu_src),
        .mem2reg(mem2reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .uncon_branch(uncon_branch),
        .alu_op(alu_op), .alu_ctrl(alu_ctrl), .result(result),
        .zero(zero), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl order: reg2loc alu_src mem2reg reg_write mem_read mem_write branch uncon_branch
    typedef struct {
        string       name;
        logic        vld;
        logic [10:0] op;
        logic [63:0] rs1, rs2, im;
        logic [7:0]  ctl;
        logic [1:0]  aop;
        logic [3:0]  actl;
        logic [63:0] res;
        logic        z, ill, ov;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctl_bus();
        return {reg2loc, alu_src, mem2reg, reg_write, mem_read, mem_write, branch, uncon_branch};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctl"}, {56'd0, ctl_bus()}, 64'd0);
        chk({tag, ".rest"}, {48'd0, out_valid, zero, illegal, alu_op, alu_ctrl, 5'd0}, 64'd0);
        chk({tag, ".result"}, result, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{"add",     1'b1, 11'h458, 64'd5,   64'd7,      64'd99,  8'b00010000, 2'b10, 4'b0010, 64'd12,    1'b0, 1'b0, 1'b1};
        vecs[1]  = '{"sub_eq",  1'b1, 11'h658, 64'd9,   64'd9,      64'd1,   8'b00010000, 2'b10, 4'b0110, 64'd0,     1'b1, 1'b0, 1'b1};
        vecs[2]  = '{"add_wrap",1'b1, 11'h458, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd5, 8'b00010000, 2'b10, 4'b0010, 64'd0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{"ldur",    1'b1, 11'h7C2, 64'h100, 64'hDEAD,   64'd8,   8'b01111000, 2'b00, 4'b0010, 64'h108,   1'b0, 1'b0, 1'b1};
        vecs[4]  = '{"stur",    1'b1, 11'h7C0, 64'h200, 64'h55,     64'h10,  8'b11000100, 2'b00, 4'b0010, 64'h210,   1'b0, 1'b0, 1'b1};
        vecs[5]  = '{"cbz_z",   1'b1, 11'h5A3, 64'h77,  64'd0,      64'd3,   8'b10000010, 2'b01, 4'b0111, 64'd0,     1'b1, 1'b0, 1'b1};
        vecs[6]  = '{"cbz_nz",  1'b1, 11'h5A3, 64'h77,  64'd4,      64'd3,   8'b10000010, 2'b01, 4'b0111, 64'd4,     1'b0, 1'b0, 1'b1};
        vecs[7]  = '{"b",       1'b1, 11'h0A5, 64'd3,   64'd4,      64'h100, 8'b00000001, 2'b00, 4'b0010, 64'd7,     1'b0, 1'b0, 1'b1};
        vecs[8]  = '{"illegal", 1'b1, 11'h7FF, 64'd1,   64'd2,      64'd0,   8'b00000000, 2'b00, 4'b0010, 64'd3,     1'b0, 1'b1, 1'b1};
        vecs[9]  = '{"bubble",  1'b0, 11'h458, 64'd100, 64'd200,    64'd0,   8'b00000000, 2'b00, 4'b0000, 64'd3,     1'b0, 1'b0, 1'b0};
        vecs[10] = '{"and",     1'b1, 11'h450, 64'hF0,  64'h3C,     64'hFF,  8'b00010000, 2'b10, 4'b0000, 64'h30,    1'b0, 1'b0, 1'b1};
        vecs[11] = '{"orr",     1'b1, 11'h550, 64'hF0,  64'h3C,     64'hFF,  8'b00010000, 2'b10, 4'b0001, 64'hFC,    1'b0, 1'b0, 1'b1};

        // Reset held with a valid ADD presented and the clock running.
        rst = 1'b1; in_valid = 1'b1; opcode = 11'h458;
        rs1_data = 64'd5; rs2_data = 64'd7; imm = 64'd0;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            in_valid = vecs[i].vld; opcode = vecs[i].op;
            rs1_data = vecs[i].rs1; rs2_data = vecs[i].rs2; imm = vecs[i].im;
            @(posedge clk);
            #1;
            chk({vecs[i].name, ".ctl"},      {56'd0, ctl_bus()},  {56'd0, vecs[i].ctl});
            chk({vecs[i].name, ".alu_op"},   {62'd0, alu_op},     {62'd0, vecs[i].aop});
            chk({vecs[i].name, ".alu_ctrl"}, {60'd0, alu_ctrl},   {60'd0, vecs[i].actl});
            chk({vecs[i].name, ".result"},   result,              vecs[i].res);
            chk({vecs[i].name, ".flags"},    {61'd0, zero, illegal, out_valid},
                                             {61'd0, vecs[i].z, vecs[i].ill, vecs[i].ov});
            $display("vec %0d %s: op=0x%0h result=0x%0h zero=%0b ill=%0b ov=%0b",
                     i, vecs[i].name, vecs[i].op, result, zero, illegal, out_valid);
            @(negedge clk);
        end

        // Mid-stream reset: clears outputs at once and drops the in-flight op.
        in_valid = 1'b1; opcode = 11'h458; rs1_data = 64'd1; rs2_data = 64'd1;
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #1 chk("rst_hold.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_hold.result", result, 64'd0);
        $display("mid-stream reset: out_valid=%0b result=0x%0h", out_valid, result);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("post_rst.result", result, 64'd2);
        chk("post_rst.out_valid", {63'd0, out_valid}, 64'd1);

        // Input changes between edges must not reach the outputs.
        #2 opcode = 11'h658; rs1_data = 64'd50; rs2_data = 64'd8; in_valid = 1'b0;
        #1 chk("between_edges.result", result, 64'd2);
        chk("between_edges.alu_ctrl", {60'd0, alu_ctrl}, 64'd2);
        chk("between_edges.out_valid", {63'd0, out_valid}, 64'd1);
        $display("between-edge change: result=0x%0h alu_ctrl=%0b", result, alu_ctrl);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
